// File: rtl/traffic_demand_scheduler_if.sv
// Signal bundle between the demand scheduler and its neighbours.
// Handshake: there is no back-pressure. The producer side (master) drives
// enable/tick/carA/carB every cycle. The scheduler (slave) presents
// lastA/lastB/extA/extB as registered levels. `update` is a one-cycle valid
// strobe marking the cycle in which those levels take new values; there is
// no ready, so a consumer must sample in that cycle or simply read the levels.
interface traffic_demand_scheduler_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             tick;
    logic             carA;
    logic             carB;
    logic [CNT_W-1:0] lastA;
    logic [CNT_W-1:0] lastB;
    logic [2:0]       extA;
    logic [2:0]       extB;
    logic             update;
    logic [1:0]       dbg_state;

    modport master (
        output enable, tick, carA, carB,
        input  lastA, lastB, extA, extB, update, dbg_state
    );

    modport slave (
        input  enable, tick, carA, carB,
        output lastA, lastB, extA, extB, update, dbg_state
    );
endinterface

// File: rtl/traffic_demand_scheduler.sv
// Counts vehicle arrivals on approaches A and B over windows of WINDOW_TICKS
// time-base ticks, publishes the counts, and grants green extensions from the
// ratio of the two counts using shift-add multiply-compare (no divider).
module traffic_demand_scheduler #(
    parameter int WINDOW_TICKS = 60,
    parameter int CNT_W        = 8
) (
    input logic                        clock,
    input logic                        reset,
    traffic_demand_scheduler_if.slave  bus
);

    localparam logic [7:0]       LAST_TICK = 8'(WINDOW_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_CALC  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             carA_q;
    logic             carB_q;
    logic             evA;
    logic             evB;
    logic             terminal;
    logic [7:0]       win_cnt;
    logic [CNT_W-1:0] cntA;
    logic [CNT_W-1:0] cntB;
    logic [CNT_W-1:0] cntA_inc;
    logic [CNT_W-1:0] cntB_inc;
    logic [CNT_W-1:0] snapA;
    logic [CNT_W-1:0] snapB;
    logic [CNT_W-1:0] lastA_q;
    logic [CNT_W-1:0] lastB_q;
    logic [2:0]       extA_q;
    logic [2:0]       extB_q;
    logic             update_q;

    // Saturating +1: a full counter stays full instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic ev);
        if (ev && (c != CNT_MAX)) begin
            return c + CNT_W'(1);
        end
        return c;
    endfunction

    // Extension for `own` against `other`. Products are CNT_W+3 bits wide so
    // 5*other cannot overflow; zero counts are handled before any compare.
    function automatic logic [2:0] grant(input logic [CNT_W-1:0] own,
                                         input logic [CNT_W-1:0] other);
        logic [CNT_W+2:0] own_x;
        logic [CNT_W+2:0] three_x;
        logic [CNT_W+2:0] five_x;
        own_x   = {3'b000, own};
        three_x = {2'b00, other, 1'b0} + {3'b000, other};
        five_x  = {1'b0, other, 2'b00} + {3'b000, other};
        if (own == '0) begin
            return 3'd0;
        end else if (other == '0) begin
            return 3'd4;
        end else if (own_x >= five_x) begin
            return 3'd4;
        end else if (own_x >= three_x) begin
            return 3'd2;
        end
        return 3'd0;
    endfunction

    assign evA      = bus.carA & ~carA_q;
    assign evB      = bus.carB & ~carB_q;
    assign cntA_inc = sat_inc(cntA, evA);
    assign cntB_inc = sat_inc(cntB, evB);
    assign terminal = (state_q == ST_COUNT) && bus.tick && (win_cnt == LAST_TICK);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping enable wins from every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_COUNT;
            ST_COUNT: if (terminal) state_d = ST_CALC;
            ST_CALC:  state_d = ST_COUNT;
            default:  state_d = ST_IDLE;
        endcase
        if (!bus.enable) begin
            state_d = ST_IDLE;
        end
    end

    // Previous detector levels for rising-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            carA_q <= 1'b0;
            carB_q <= 1'b0;
        end else begin
            carA_q <= bus.carA;
            carB_q <= bus.carB;
        end
    end

    // Window counters and snapshot; CALC keeps counting into the new window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cntA    <= '0;
            cntB    <= '0;
            win_cnt <= '0;
            snapA   <= '0;
            snapB   <= '0;
        end else if ((state_q == ST_IDLE) || !bus.enable) begin
            cntA    <= '0;
            cntB    <= '0;
            win_cnt <= '0;
        end else if (terminal) begin
            snapA   <= cntA_inc;
            snapB   <= cntB_inc;
            cntA    <= '0;
            cntB    <= '0;
            win_cnt <= '0;
        end else begin
            cntA <= cntA_inc;
            cntB <= cntB_inc;
            if (bus.tick) begin
                win_cnt <= win_cnt + 8'd1;
            end
        end
    end

    // Publish on the edge leaving CALC, even if enable has just dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lastA_q  <= '0;
            lastB_q  <= '0;
            extA_q   <= 3'd0;
            extB_q   <= 3'd0;
            update_q <= 1'b0;
        end else begin
            update_q <= (state_q == ST_CALC);
            if (state_q == ST_CALC) begin
                lastA_q <= snapA;
                lastB_q <= snapB;
                extA_q  <= grant(snapA, snapB);
                extB_q  <= grant(snapB, snapA);
            end
        end
    end

    assign bus.lastA     = lastA_q;
    assign bus.lastB     = lastB_q;
    assign bus.extA      = extA_q;
    assign bus.extB      = extB_q;
    assign bus.update    = update_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_traffic_demand_scheduler.sv
// Bench for traffic_demand_scheduler with a 4-tick window: table of whole
// windows with known results, hand-built boundary sequences, and a random
// run, all compared cycle by cycle against a window-level reference model.
module tb_traffic_demand_scheduler;

    localparam int W     = 4;
    localparam int CNT_W = 8;
    localparam int MAXC  = 255;

    logic clock;
    logic reset;

    traffic_demand_scheduler_if #(.CNT_W(CNT_W)) bus ();

    traffic_demand_scheduler #(
        .WINDOW_TICKS (W),
        .CNT_W        (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int upd_count;
    int got_la, got_lb, got_ea, got_eb;

    logic [2*CNT_W+5:0] exp_q[$];

    // ---------------- reference model ----------------
    // Tracks only: was the block enabled last edge, edges seen this window,
    // ticks seen this window, and a finished window awaiting publication.
    int  m_prev_en, m_prev_a, m_prev_b;
    int  m_ca, m_cb, m_ticks, m_pend, m_sa, m_sb;
    int  exp_la, exp_lb, exp_ea, exp_eb, exp_upd;

    function automatic int ref_grant(input int own, input int oth);
        if (own == 0) return 0;
        if (oth == 0) return 4;
        if (own >= 5 * oth) return 4;
        if (own >= 3 * oth) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_prev_en = 0; m_prev_a = 0; m_prev_b = 0;
        m_ca = 0; m_cb = 0; m_ticks = 0; m_pend = 0; m_sa = 0; m_sb = 0;
        exp_la = 0; exp_lb = 0; exp_ea = 0; exp_eb = 0; exp_upd = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input int en, input int tk, input int a, input int b);
        int ea, eb;
        ea = (a != 0 && m_prev_a == 0) ? 1 : 0;
        eb = (b != 0 && m_prev_b == 0) ? 1 : 0;
        exp_upd = 0;
        if (m_pend != 0) begin
            exp_la  = m_sa;
            exp_lb  = m_sb;
            exp_ea  = ref_grant(m_sa, m_sb);
            exp_eb  = ref_grant(m_sb, m_sa);
            exp_upd = 1;
            m_pend  = 0;
            exp_q.push_back({8'(exp_la), 8'(exp_lb), 3'(exp_ea), 3'(exp_eb)});
        end
        if (m_prev_en != 0 && en != 0) begin
            m_ca    = (m_ca + ea > MAXC) ? MAXC : m_ca + ea;
            m_cb    = (m_cb + eb > MAXC) ? MAXC : m_cb + eb;
            m_ticks = m_ticks + tk;
            if (m_ticks == W) begin
                m_pend  = 1;
                m_sa    = m_ca;
                m_sb    = m_cb;
                m_ca    = 0;
                m_cb    = 0;
                m_ticks = 0;
            end
        end else begin
            m_ca = 0; m_cb = 0; m_ticks = 0;
        end
        m_prev_en = en;
        m_prev_a  = a;
        m_prev_b  = b;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [2*CNT_W+5:0] e;
        chk("update", int'(bus.update), exp_upd);
        chk("lastA", int'(bus.lastA), exp_la);
        chk("lastB", int'(bus.lastB), exp_lb);
        chk("extA", int'(bus.extA), exp_ea);
        chk("extB", int'(bus.extB), exp_eb);
        if (bus.update) begin
            upd_count++;
            got_la = int'(bus.lastA);
            got_lb = int'(bus.lastB);
            got_ea = int'(bus.extA);
            got_eb = int'(bus.extB);
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_update", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_publish", int'({bus.lastA, bus.lastB, bus.extA, bus.extB}), int'(e));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: drive at the falling edge, model the rising edge,
    // compare at the next falling edge.
    task automatic cyc(input int en, input int tk, input int a, input int b);
        bus.enable = 1'(en);
        bus.tick   = 1'(tk);
        bus.carA   = 1'(a);
        bus.carB   = 1'(b);
        @(posedge clock);
        if (!reset) model_reset();
        else        model_step(en, tk, a, b);
        @(negedge clock);
        check_outputs();
    endtask

    // na A-edges and nb B-edges followed by exactly W ticks, the last one
    // closing the window.
    task automatic run_window(input int na, input int nb);
        int l, a, b, tk;
        l = 2 * ((na > nb) ? na : nb) + 8;
        for (int i = 0; i < l; i++) begin
            a  = (i < 2 * na && (i % 2) == 1) ? 1 : 0;
            b  = (i < 2 * nb && (i % 2) == 1) ? 1 : 0;
            tk = (i == l - 1 || i == l - 3 || i == l - 5 || i == l - 7) ? 1 : 0;
            cyc(1, tk, a, b);
        end
    endtask

    task automatic expect_window(input string name, input int la, input int lb,
                                 input int ea, input int eb);
        chk({name, "_updates"}, upd_count, 1);
        chk({name, "_lastA"}, got_la, la);
        chk({name, "_lastB"}, got_lb, lb);
        chk({name, "_extA"}, got_ea, ea);
        chk({name, "_extB"}, got_eb, eb);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int na;
        int nb;
        int la;
        int lb;
        int ea;
        int eb;
    } vec_t;

    vec_t vecs[10];
    int   held_la;

    initial begin
        vecs[0] = '{12,  3,  12,  3, 2, 0};
        vecs[1] = '{10,  2,  10,  2, 4, 0};
        vecs[2] = '{ 7,  0,   7,  0, 4, 0};
        vecs[3] = '{ 0,  0,   0,  0, 0, 0};
        vecs[4] = '{ 3, 12,   3, 12, 0, 2};
        vecs[5] = '{ 5,  1,   5,  1, 4, 0};
        vecs[6] = '{ 4,  1,   4,  1, 2, 0};
        vecs[7] = '{ 2,  1,   2,  1, 0, 0};
        vecs[8] = '{ 1,  5,   1,  5, 0, 4};
        vecs[9] = '{300, 0, 255,  0, 4, 0};

        // Reset held, then released with enable low and carA toggling.
        model_reset();
        upd_count  = 0;
        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.tick   = 1'b0;
        bus.carA   = 1'b0;
        bus.carB   = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) cyc(0, 0, i % 2, 0);
        reset = 1'b1;
        for (int i = 0; i < 100; i++) cyc(0, (i % 7 == 0) ? 1 : 0, i % 2, 0);
        chk("idle_no_update", upd_count, 0);
        chk("idle_state", int'(bus.dbg_state), 0);

        // Enable: one IDLE cycle, then windows from the table.
        cyc(1, 0, 0, 0);
        foreach (vecs[k]) begin
            upd_count = 0;
            run_window(vecs[k].na, vecs[k].nb);
            for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
            expect_window($sformatf("vec%0d", k), vecs[k].la, vecs[k].lb,
                          vecs[k].ea, vecs[k].eb);
        end

        // Edge on the terminal tick closes into the old window; edge in CALC
        // and simultaneous edges go into the next one.
        upd_count = 0;
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 0, 0, 1);
        chk("calc_update_latency", upd_count, 1);
        expect_window("term_edge", 3, 0, 4, 0);
        upd_count = 0;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 1);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        expect_window("calc_edge", 1, 2, 0, 0);

        // A level held high counts once.
        upd_count = 0;
        for (int i = 0; i < 50; i++) cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        expect_window("held_high", 1, 0, 4, 0);

        // Enable dropped mid-window: window discarded, outputs retained.
        upd_count = 0;
        held_la   = int'(bus.lastA);
        cyc(1, 1, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 1);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        chk("drop_no_update", upd_count, 0);
        chk("drop_hold_lastA", int'(bus.lastA), held_la);
        cyc(1, 0, 0, 0);
        run_window(2, 6);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        expect_window("reenable", 2, 6, 0, 2);

        // Enable dropped in the CALC cycle: publish still happens.
        upd_count = 0;
        run_window(5, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        expect_window("drop_in_calc", 5, 1, 4, 0);
        chk("drop_in_calc_idle", int'(bus.dbg_state), 0);

        // Reset mid-window clears outputs without waiting for a clock.
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("async_rst_lastA", int'(bus.lastA), 0);
        chk("async_rst_lastB", int'(bus.lastB), 0);
        chk("async_rst_extA", int'(bus.extA), 0);
        chk("async_rst_update", int'(bus.update), 0);
        model_reset();
        @(negedge clock);
        cyc(0, 0, 0, 0);
        reset = 1'b1;
        cyc(0, 0, 0, 0);

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 97) ? 1 : 0,
                ($urandom_range(0, 3) == 0) ? 1 : 0,
                $urandom_range(0, 1), $urandom_range(0, 1));
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
